param_pipelined_counter: RTL
============================

Name: param_pipelined_counter

Overview:
Parametrised successor to the fixed 16-bit, 4-stage pipelined counter. A chain of DEPTH registers presents a counting sequence at the output stage. The head stage advances by STEP and every other stage takes its upstream neighbour, so the output lags the head by DEPTH-1 cycles. Adds clock-enable stall, synchronous reload, wrap or saturate overflow mode, and a per-stage overflow flag that travels with the data. Used as a stimulus source and reference model in parametric pipeline-depth checks.

Parameters:
WIDTH, 16, bit width of every stage and of out/load_val.
DEPTH, 4, number of stages including the output stage; legal range 2..32.
STEP, 1, increment applied at the head stage; WIDTH-bit unsigned, 0 legal.
INIT, 0, value loaded into the output stage at reset.
SAT, 0, overflow mode: 0 = wrap modulo 2^WIDTH, 1 = saturate at 2^WIDTH-1.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  advance pipeline; when low all stages and flags hold.
load  input  1  synchronous reload of all stages from load_val.
load_val  input  WIDTH  base value for reload.
out  output  WIDTH  output stage value, s[0].
out_ovf  output  1  overflow flag attached to s[0].

Behaviour:
- State: stages s[0..DEPTH-1], s[0] drives out, s[DEPTH-1] is the head; flags f[0..DEPTH-1], f[0] drives out_ovf.
- Priority at each rising edge: rst, then load, then en, then hold.
- rst=1: s[k] <= INIT + k*STEP and f[k] <= 0 for all k.
  - Next cycle: out=INIT, out_ovf=0.
  - Seed arithmetic follows the SAT rule: wraps modulo 2^WIDTH, or clamps to 2^WIDTH-1 when SAT=1.
  - Reset mid-sequence discards all in-flight values.
- load=1 (rst=0): s[k] <= load_val + k*STEP (same SAT rule) and f[k] <= 0.
  - Next cycle: out=load_val.
  - load takes effect regardless of en.
- en=1 (rst=0, load=0):
  - s[k] <= s[k+1] and f[k] <= f[k+1] for k < DEPTH-1.
  - Head update computes sum = s[DEPTH-1] + STEP with a WIDTH+1-bit carry.
  - carry=0: s[DEPTH-1] <= sum, f[DEPTH-1] <= 0.
  - carry=1, SAT=0: s[DEPTH-1] <= sum modulo 2^WIDTH, f[DEPTH-1] <= 1.
  - carry=1, SAT=1: s[DEPTH-1] <= 2^WIDTH-1, f[DEPTH-1] <= 1.
  - In SAT=1 mode, once the head is at max with STEP>0, every later head value carries f=1.
- en=0: full hold; out and out_ovf are stable.
- Latency:
  - The output reaches a head value DEPTH-1 enabled cycles after it is produced.
  - After reset or load, each enabled cycle shifts the precomputed seed sequence toward out.
  - The out sequence is therefore contiguous (INIT, INIT+STEP, ...) with no bubble.
- STEP=0: head constant; carry never occurs, so out_ovf stays 0.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Default params (WIDTH=16, DEPTH=4, STEP=1, INIT=0, SAT=0):
  - Stimulus: rst for 1 cycle, then en=1 for 8 cycles.
  - Required response: out = 0,1,2,3,4,5,6,7,8 on successive cycles; out_ovf=0 throughout.
- Stall, default params:
  - Stimulus: after out=2, drop en for 3 cycles, then raise en.
  - Required response: out holds 2 for 3 cycles, then resumes 3,4,5.
- Wrap (WIDTH=4, DEPTH=4, SAT=0):
  - Stimulus: load=1 with load_val=10, then en=1.
  - Required response: out = 10,11,12,13,14,15,0,1.
  - out_ovf=1 only on the first 0 (head went 15 to 0), which reaches out 3 cycles after the head wrapped.
- Saturate (WIDTH=4, DEPTH=4, SAT=1):
  - Stimulus: same as the wrap case.
  - Required response: out = 10,11,12,13,14,15,15,15,...
  - out_ovf=0 on the first 15 and 1 on every later 15.
- Priority:
  - Stimulus: assert rst and load together with load_val=7.
  - Required response: next cycle out=INIT (0).
  - Stimulus: then load=1 with en=0 and load_val=7.
  - Required response: next cycle out=7.
- Seed overflow (WIDTH=4, DEPTH=4, STEP=5, INIT=12, SAT=1):
  - Stimulus: rst for 1 cycle, then en=1.
  - Required response: seeds are 12,15,15,15 with all f=0; out = 12,15,15,15,15 with out_ovf=1 from the fifth value on.
  - Rerun with SAT=0: seeds are 12,1,6,11 and out = 12,1,6,11,0 with out_ovf=1 on the 0.

Source files
------------

// File: rtl/param_pipelined_counter.sv
// Parametrised pipelined counter: DEPTH-stage register chain whose head advances by STEP,
// with stall, synchronous reload, wrap/saturate overflow and a per-stage overflow flag.
module param_pipelined_counter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int STEP  = 1,
    parameter int INIT  = 0,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             out_ovf
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
    localparam bit               SAT_EN = (SAT != 0);

    logic [WIDTH-1:0] s    [DEPTH];
    logic [WIDTH-1:0] seed [DEPTH];
    logic [DEPTH-1:0] f;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] prev;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] head_next;

    // Seed chain base + k*STEP, built incrementally; clamping each step equals clamping the product.
    always_comb begin
        base    = rst ? INIT_W : load_val;
        prev    = base;
        acc     = '0;
        seed[0] = base;
        for (int k = 1; k < DEPTH; k++) begin
            acc     = {1'b0, prev} + {1'b0, STEP_W};
            prev    = (acc[WIDTH] && SAT_EN) ? '1 : acc[WIDTH-1:0];
            seed[k] = prev;
        end
    end

    always_comb begin
        sum       = {1'b0, s[DEPTH-1]} + {1'b0, STEP_W};
        head_next = (sum[WIDTH] && SAT_EN) ? '1 : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            for (int k = 0; k < DEPTH; k++) begin
                s[k] <= seed[k];
            end
            f <= '0;
        end else if (en) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                s[k] <= s[k+1];
            end
            s[DEPTH-1] <= head_next;
            f          <= {sum[WIDTH], f[DEPTH-1:1]};
        end
    end

    assign out     = s[0];
    assign out_ovf = f[0];

endmodule
